// File: rtl/vocab_scan_encoder.sv
// vocab_scan_encoder: accepts a query key over a valid/ready handshake, scans an external
// vocabulary SRAM (1-cycle read latency) entry by entry and returns the first (or last) matching
// token index, a found flag and a saturating hit count over a backpressured output handshake.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   in_valid/in_ready  query handshake; in_ready is high only in IDLE
//   in_key             query key
//   vocab_addr/re      registered SRAM read address and read enable
//   vocab_dout         SRAM data for the address presented on the previous cycle
//   out_valid/ready    result handshake
//   out_token          matching index (0 when not found)
//   out_found          at least one entry matched
//   out_hits           number of matching entries, saturating at all-ones
//   busy               state is not IDLE
module vocab_scan_encoder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned VOCAB_SIZE = 16,
  parameter bit          MATCH_LAST = 1'b0,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_key,
  output logic [ADDR_WIDTH-1:0] vocab_addr,
  output logic                  vocab_re,
  input  logic [DATA_WIDTH-1:0] vocab_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_token,
  output logic                  out_found,
  output logic [CNT_WIDTH-1:0]  out_hits,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StScan, StFlush, StDone} state_e;

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(VOCAB_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0]  HitsMax  = '1;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   key_q, key_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   addr_dly_q, addr_dly_d;  // address whose data is on vocab_dout now
  logic                    re_q, re_d;
  logic                    rdv_q, rdv_d;            // vocab_dout carries a requested word
  logic [ADDR_WIDTH-1:0]   token_q, token_d;
  logic                    found_q, found_d;
  logic [CNT_WIDTH-1:0]    hits_q, hits_d;
  logic                    hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      key_q      <= '0;
      addr_q     <= '0;
      addr_dly_q <= '0;
      re_q       <= 1'b0;
      rdv_q      <= 1'b0;
      token_q    <= '0;
      found_q    <= 1'b0;
      hits_q     <= '0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      addr_q     <= addr_d;
      addr_dly_q <= addr_dly_d;
      re_q       <= re_d;
      rdv_q      <= rdv_d;
      token_q    <= token_d;
      found_q    <= found_d;
      hits_q     <= hits_d;
    end
  end

  // Compares only count while scanning; a read issued in the last SCAN cycle of an early stop
  // lands in DONE and must be ignored.
  assign hit = rdv_q && (vocab_dout == key_q) && ((state_q == StScan) || (state_q == StFlush));

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    addr_d     = addr_q;
    addr_dly_d = addr_q;
    re_d       = re_q;
    rdv_d      = re_q;
    token_d    = token_q;
    found_d    = found_q;
    hits_d     = hits_q;

    if (hit) begin
      found_d = 1'b1;
      token_d = addr_dly_q;
      if (hits_q != HitsMax) begin
        hits_d = hits_q + 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          key_d   = in_key;
          hits_d  = '0;
          token_d = '0;
          found_d = 1'b0;
          addr_d  = '0;
          re_d    = 1'b1;
          state_d = StScan;
        end
      end
      StScan: begin
        if (hit && !MATCH_LAST) begin
          re_d    = 1'b0;
          state_d = StDone;
        end else if (addr_q == LastAddr) begin
          // Hold the address so it cannot wrap; the final compare happens in FLUSH.
          re_d    = 1'b0;
          state_d = StFlush;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      StFlush: begin
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign in_ready   = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign out_valid  = (state_q == StDone);
  assign vocab_addr = addr_q;
  assign vocab_re   = re_q;
  assign out_token  = token_q;
  assign out_found  = found_q;
  assign out_hits   = hits_q;

endmodule

// File: doc/vocab_scan_encoder.md
Name: vocab_scan_encoder

Overview:
- Parametrised successor of the single-word vocab matcher.
- Accepts query keys over a valid/ready handshake and scans an external vocabulary SRAM (1-cycle read latency) entry by entry.
- Returns the token index of the first or last matching entry, a found flag and a saturating hit count over an output handshake with backpressure.
- Sits between the input-word buffer and the downstream embedding lookup.

Parameters:
- DATA_WIDTH, 8: width of one key and one vocab SRAM word.
- ADDR_WIDTH, 4: vocab SRAM address width.
- VOCAB_SIZE, 16: number of valid vocab entries scanned, 1..2**ADDR_WIDTH.
- MATCH_LAST, 0: 0 = stop at first match; 1 = scan all entries and report the highest matching index.
- CNT_WIDTH, 4: width of the hit counter; saturates at all-ones.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  query key valid.
- in_ready  output  1  block can accept a key; high only in IDLE.
- in_key  input  DATA_WIDTH  query key.
- vocab_addr  output  ADDR_WIDTH  registered SRAM read address.
- vocab_re  output  1  SRAM read enable/chip select.
- vocab_dout  input  DATA_WIDTH  SRAM data for the address presented on the previous cycle.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_token  output  ADDR_WIDTH  matching index; 0 when not found.
- out_found  output  1  at least one entry matched.
- out_hits  output  CNT_WIDTH  number of matching entries scanned, saturating.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (rst high at an edge):
  - State goes to IDLE.
  - in_ready=1 in the following cycle; all other outputs are 0: out_valid, out_token, out_found, out_hits, vocab_addr, vocab_re, busy.
  - Reset wins over any handshake in the same cycle and abandons a scan or pending result mid-operation; the result is not delivered.
- States: IDLE, SCAN, FLUSH, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch in_key, clear the hit counter, set vocab_addr=0 and vocab_re=1, and go to SCAN.
- SCAN:
  - Each cycle vocab_addr increments by 1.
  - A 1-bit read-valid pipeline flag tags vocab_dout; the compare is vocab_dout==key when the flag is set.
  - On each hit, out_hits increments, saturating at 2**CNT_WIDTH-1.
  - The matching index is the previous cycle's address, held in a delayed address register.
  - MATCH_LAST=0: on the first hit, deassert vocab_re and go to DONE with out_token=index and out_found=1.
  - MATCH_LAST=1: on each hit, update the token register and continue.
  - When the address issued is VOCAB_SIZE-1, deassert vocab_re on the next cycle, hold vocab_addr, and go to FLUSH.
- FLUSH: perform the compare of the final entry, then go to DONE.
- DONE:
  - out_valid=1; out_token, out_found and out_hits are held stable while out_valid&&!out_ready.
  - On out_valid&&out_ready, go to IDLE.
  - A new key is accepted no earlier than the cycle after the output handshake, so there is no overlap.
- Latency, with accept edge E0:
  - Address i is presented in the cycle after edge E0+i; vocab_dout is valid after edge E0+i+1.
  - MATCH_LAST=0 with first match at i: out_valid is visible after edge E0+i+2.
  - Miss, or MATCH_LAST=1: out_valid is visible after edge E0+VOCAB_SIZE+1, with out_token=0 and out_found=0 on a miss.
- Boundary conditions:
  - VOCAB_SIZE=1: SCAN lasts one cycle, then FLUSH.
  - VOCAB_SIZE=2**ADDR_WIDTH: the address must not wrap; the terminal compare uses the delayed address register.
  - A match at the last index is reported correctly in both modes.
  - An in_valid held in a non-IDLE state is ignored; the key is not latched.
  - Hit-counter saturation does not affect out_token.

Test Plan:
- Vocab {0x10..0x1F}, key 0x13, MATCH_LAST=0 -> out_valid after E0+5, out_token=3, out_found=1, out_hits=1.
- Same vocab, key 0x55 -> out_valid after E0+17, out_found=0, out_token=0, out_hits=0.
- Vocab with 0xAA at indices 2, 7, 15; MATCH_LAST=1 -> out_token=15, out_hits=3; same vocab with MATCH_LAST=0 -> out_token=2, out_hits=1.
- All 16 entries 0xAA, CNT_WIDTH=3 -> out_hits saturates at 7, out_token=15 (MATCH_LAST=1).
- out_ready held low 10 cycles after a result -> out_valid and all result fields stable and in_ready=0; a new in_valid is ignored until after the handshake.
- rst pulsed at cycle 4 of a scan -> next cycle in_ready=1, out_valid=0, busy=0, vocab_re=0; the next key 0x1F yields out_token=15.
